// File: rtl/mem_bist_pkg.sv
// Shared types and the data-pattern generator for the memory BIST controller.
package mem_bist_pkg;

  typedef enum logic [1:0] {
    ZERO     = 2'd0,
    ADDR     = 2'd1,
    CHECKER  = 2'd2,
    INV_ADDR = 2'd3
  } mode_e;

  typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, DONE} state_e;

  localparam int PAT_W = 64;

  // Widest-case pattern; callers cast the result down to their data width.
  function automatic logic [PAT_W-1:0] pat(mode_e m, logic [PAT_W-1:0] a, int dw);
    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] p;
    mask = (dw >= PAT_W) ? '1 : ((PAT_W'(1) << dw) - PAT_W'(1));
    case (m)
      ZERO:    p = '0;
      ADDR:    p = a;
      CHECKER: p = a[0] ? {(PAT_W/2){2'b10}} : {(PAT_W/2){2'b01}};
      default: p = ~a;
    endcase
    return p & mask;
  endfunction

endpackage

// File: rtl/mem_bist_ctrl_if.sv
// Single-port memory bus between the BIST controller and the memory port mux.
interface mem_bist_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output addr, read, write, data_in, input data_out);
  modport slave  (input addr, read, write, data_in, output data_out);
endinterface

// File: rtl/mem_bist_rd_pipe.sv
// Carries address and expected data of each issued read until its data returns.
module mem_bist_rd_pipe #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_exp,
  output logic              out_vld,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_exp
);
  logic [RD_LAT-1:0]             vld_pipe;
  logic [RD_LAT-1:0][ADDR_W-1:0] addr_pipe;
  logic [RD_LAT-1:0][DATA_W-1:0] exp_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Payload needs no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    addr_pipe[0] <= in_addr;
    exp_pipe[0]  <= in_exp;
    for (int i = 1; i < RD_LAT; i++) begin
      addr_pipe[i] <= addr_pipe[i-1];
      exp_pipe[i]  <= exp_pipe[i-1];
    end
  end

  assign out_vld  = vld_pipe[RD_LAT-1];
  assign out_addr = addr_pipe[RD_LAT-1];
  assign out_exp  = exp_pipe[RD_LAT-1];
endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: write a pattern, read it back pipelined, count and log mismatches.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  mem_bist_ctrl_if.master     mem,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_cnt,
  output logic                first_err_valid,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [DATA_W-1:0]   first_err_data
);
  state_e            state;
  mode_e             mode_q;
  logic [ADDR_W-1:0] cnt;
  logic [2:0]        dcnt;

  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_exp;
  logic [DATA_W-1:0] rd_exp;
  logic              mis;
  logic [ERR_W-1:0]  err_nxt;

  // Pipe is fed from the registered strobe so its depth matches the memory latency.
  assign rd_exp = DATA_W'(pat(mode_q, PAT_W'(mem.addr), DATA_W));

  mem_bist_rd_pipe #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (mem.read),
    .in_addr (mem.addr),
    .in_exp  (rd_exp),
    .out_vld (cmp_vld),
    .out_addr(cmp_addr),
    .out_exp (cmp_exp)
  );

  assign mis     = cmp_vld && (mem.data_out != cmp_exp);
  assign err_nxt = (mis && (err_cnt != '1)) ? err_cnt + ERR_W'(1) : err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      mode_q          <= ZERO;
      cnt             <= '0;
      dcnt            <= '0;
      mem.addr        <= '0;
      mem.read        <= 1'b0;
      mem.write       <= 1'b0;
      mem.data_in     <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      first_err_data  <= '0;
    end else begin
      done    <= 1'b0;
      err_cnt <= err_nxt;
      if (mis && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_addr  <= cmp_addr;
        first_err_data  <= mem.data_out;
      end
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            mode_q          <= mode_e'(mode);
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_data  <= '0;
            cnt             <= '0;
            busy            <= 1'b1;
            state           <= WR;
          end
        end
        WR: begin
          mem.write   <= 1'b1;
          mem.read    <= 1'b0;
          mem.addr    <= cnt;
          mem.data_in <= DATA_W'(pat(mode_q, PAT_W'(cnt), DATA_W));
          cnt         <= cnt + ADDR_W'(1);
          if (cnt == '1) state <= RD;
        end
        RD: begin
          mem.write   <= 1'b0;
          mem.read    <= 1'b1;
          mem.addr    <= cnt;
          mem.data_in <= '0;
          cnt         <= cnt + ADDR_W'(1);
          if (cnt == '1) begin
            dcnt  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          mem.read  <= 1'b0;
          mem.write <= 1'b0;
          mem.addr  <= '0;
          dcnt      <= dcnt + 3'd1;
          if (dcnt == 3'(RD_LAT - 1)) state <= DONE;
        end
        DONE: begin
          // The last compare retires on this edge, so judge on the next count.
          done  <= 1'b1;
          pass  <= (err_nxt == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed scoreboard bench: two controllers (RD_LAT=1/ERR_W=8 and RD_LAT=2/ERR_W=3) on behavioural memories.
module tb_mem_bist_ctrl;
  localparam logic [1:0] M_ZERO = 2'd0, M_ADDR = 2'd1, M_CHK = 2'd2, M_INV = 2'd3;

  typedef struct {
    int lat;
    int pass;
    int err;
    int fev;
    int fea;
    int fed;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, st_a, st_b;
  logic [1:0] md_a, md_b;
  int         fm_a, fm_b;
  logic       busy_a, done_a, pass_a, fev_a, busy_b, done_b, pass_b, fev_b;
  logic [7:0] err_a, fed_a, fed_b;
  logic [2:0] err_b;
  logic [4:0] fea_a, fea_b;

  mem_bist_ctrl_if #(.ADDR_W(5), .DATA_W(8)) if_a ();
  mem_bist_ctrl_if #(.ADDR_W(5), .DATA_W(8)) if_b ();

  mem_bist_ctrl u_a (
    .clk(clk), .rst_n(rst_a), .start(st_a), .mode(md_a), .mem(if_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_err_valid(fev_a), .first_err_addr(fea_a), .first_err_data(fed_a)
  );

  mem_bist_ctrl #(.RD_LAT(2), .ERR_W(3)) u_b (
    .clk(clk), .rst_n(rst_b), .start(st_b), .mode(md_b), .mem(if_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_err_valid(fev_b), .first_err_addr(fea_b), .first_err_data(fed_b)
  );

  // Memory models; fm: 0 good, 1 bit 3 stuck at 0, 2 always reads zero.
  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  logic [7:0] rq_a, rq_b1, rq_b2;
  always @(posedge clk) begin
    if (if_a.write) mem_a[if_a.addr] <= if_a.data_in;
    if (if_a.read)  rq_a <= mem_a[if_a.addr];
    if (if_b.write) mem_b[if_b.addr] <= if_b.data_in;
    if (if_b.read)  rq_b1 <= mem_b[if_b.addr];
    rq_b2 <= rq_b1;
  end
  assign if_a.data_out = (fm_a == 1) ? (rq_a & 8'hF7) : (fm_a == 2) ? 8'h00 : rq_a;
  assign if_b.data_out = (fm_b == 2) ? 8'h00 : (fm_b == 1) ? (rq_b2 & 8'hF7) : rq_b2;

  bit         sel;
  logic       busy_s, dn_s, pass_s, fev_s, r_s, w_s;
  logic [7:0] err_s, fed_s, din_s;
  logic [4:0] fea_s, a_s;
  assign busy_s = sel ? busy_b : busy_a;
  assign dn_s   = sel ? done_b : done_a;
  assign pass_s = sel ? pass_b : pass_a;
  assign fev_s  = sel ? fev_b  : fev_a;
  assign err_s  = sel ? {5'd0, err_b} : err_a;
  assign fea_s  = sel ? fea_b  : fea_a;
  assign fed_s  = sel ? fed_b  : fed_a;
  assign r_s    = sel ? if_b.read    : if_a.read;
  assign w_s    = sel ? if_b.write   : if_a.write;
  assign a_s    = sel ? if_b.addr    : if_a.addr;
  assign din_s  = sel ? if_b.data_in : if_a.data_in;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tpat(input logic [1:0] m, input logic [4:0] a);
    case (m)
      M_ZERO:  return 8'h00;
      M_ADDR:  return {3'b000, a};
      M_CHK:   return a[0] ? 8'hAA : 8'h55;
      default: return ~{3'b000, a};
    endcase
  endfunction

  function automatic exp_t model(input bit s, input logic [1:0] m, input int fm);
    exp_t e;
    int n;
    logic [7:0] w, r;
    e = '{lat: 64 + (s ? 2 : 1) + 1, pass: 0, err: 0, fev: 0, fea: 0, fed: 0};
    n = 0;
    for (int a = 0; a < 32; a++) begin
      w = tpat(m, 5'(a));
      r = (fm == 1) ? (w & 8'hF7) : (fm == 2) ? 8'h00 : w;
      if (r != w) begin
        n++;
        if (e.fev == 0) begin
          e.fev = 1;
          e.fea = a;
          e.fed = int'(r);
        end
      end
    end
    e.err  = (n > (s ? 7 : 255)) ? (s ? 7 : 255) : n;
    e.pass = (n == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input logic st, input logic [1:0] m);
    if (s) begin st_b = st; md_b = m; end
    else   begin st_a = st; md_a = m; end
  endtask

  task automatic run(input bit s, input logic [1:0] m, input int glitch, output int lat,
                     output int ndone, output int bad, output int rdmax, output int rdtot);
    int run_len;
    lat = -1; ndone = 0; bad = 0; rdmax = 0; rdtot = 0; run_len = 0;
    sel = s;
    drive(s, 1'b1, m);
    step();
    drive(s, 1'b0, m);
    for (int k = 1; k <= 200; k++) begin
      step();
      if (w_s) begin
        if (r_s || din_s !== tpat(m, a_s)) bad++;
      end else if (din_s !== 8'h00) bad++;
      if (r_s) begin
        run_len++;
        rdtot++;
        if (run_len > rdmax) rdmax = run_len;
      end else run_len = 0;
      if (dn_s) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (k == glitch) drive(s, 1'b1, M_ADDR);
      else if (k == glitch + 1) drive(s, 1'b0, m);
      if (lat >= 0 && k >= lat + 10) break;
    end
  endtask

  task automatic full(input string p, input bit s, input logic [1:0] m, input int fm, input int glitch);
    exp_t e;
    int lat, nd, bad, rmax, rtot;
    if (s) fm_b = fm; else fm_a = fm;
    sb.push_back(model(s, m, fm));
    run(s, m, glitch, lat, nd, bad, rmax, rtot);
    e = sb.pop_front();
    chk({p, "_done_lat"}, lat, e.lat);
    chk({p, "_done_cnt"}, nd, 1);
    chk({p, "_wr_data"}, bad, 0);
    chk({p, "_rd_total"}, rtot, 32);
    chk({p, "_rd_run"}, rmax, 32);
    chk({p, "_pass"}, 32'(pass_s), e.pass);
    chk({p, "_err_cnt"}, 32'(err_s), e.err);
    chk({p, "_fe_valid"}, 32'(fev_s), e.fev);
    chk({p, "_fe_addr"}, 32'(fea_s), e.fea);
    chk({p, "_fe_data"}, 32'(fed_s), e.fed);
    chk({p, "_busy_end"}, 32'(busy_s), 0);
  endtask

  initial begin
    int seen, nd;
    rst_a = 1'b0; rst_b = 1'b0; st_a = 1'b0; st_b = 1'b0;
    md_a = M_ZERO; md_b = M_ZERO; fm_a = 0; fm_b = 0; sel = 1'b0;
    repeat (3) step();
    rst_a = 1'b1; rst_b = 1'b1;
    step();

    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_pass", 32'(pass_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_fev", 32'(fev_a), 0);
    chk("rst_rw", {30'd0, if_a.read, if_a.write}, 0);
    chk("rst_addr", 32'(if_a.addr), 0);
    chk("rst_din", 32'(if_a.data_in), 0);
    chk("rst_b_busy", 32'(busy_b), 0);

    full("t1_zero", 1'b0, M_ZERO, 0, -1);
    full("t2_stuck", 1'b0, M_ADDR, 1, -1);
    full("t3_chk_lat2", 1'b1, M_CHK, 0, -1);
    full("t4_sat", 1'b1, M_INV, 2, -1);

    // Abort a test mid-read with a one-clock reset.
    sel = 1'b0;
    fm_a = 1;
    drive(1'b0, 1'b1, M_ADDR);
    step();
    drive(1'b0, 1'b0, M_ADDR);
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (r_s) begin
        seen = 1;
        break;
      end
    end
    chk("t5_rd_seen", seen, 1);
    repeat (20) step();
    chk("t5_err_before", 32'(err_s != 8'd0), 1);
    rst_a = 1'b0;
    step();
    rst_a = 1'b1;
    chk("t5_busy", 32'(busy_s), 0);
    chk("t5_read", 32'(r_s), 0);
    chk("t5_err", 32'(err_s), 0);
    chk("t5_done", 32'(dn_s), 0);
    nd = 0;
    repeat (80) begin
      step();
      if (dn_s) nd++;
    end
    chk("t5_no_done", nd, 0);
    full("t5_restart", 1'b0, M_ZERO, 0, -1);

    full("t6_restart_ignored", 1'b0, M_ZERO, 0, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
